byte_queue: RTL and testbench

//  Byte FIFO that sits directly downstream of the deserializer.
//  - Takes each assembled byte through the deserializer's data_ready/ack_in handshake.
//  - Buffers up to DEPTH bytes.
//  - Releases bytes one per dequeue request to the consuming logic.
//  - Back-pressure: when the queue is full, no ack is returned. The deserializer

---
 rtl/byte_queue.sv | 120 ++++++++++++
 tb/tb_byte_queue.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/byte_queue.sv
// rtl/byte_queue.sv - byte FIFO behind the deserializer with a data_ready/ack enqueue handshake
module byte_queue #(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_ready_in,
  output logic             ack_out,
  input  logic             dequeue_in,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  output logic [CW-1:0]    len_out,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACK      = 2'd1,
    ST_WAIT_LOW = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             wr_en;
  logic             rd_en;

  logic [WIDTH-1:0] mem [DEPTH];

  // Enqueue handshake: accept one byte per data_ready assertion, judged on the registered full flag
  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (data_ready_in && !full_q) begin
          wr_en   = 1'b1;
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        state_d = ST_WAIT_LOW;
      end
      ST_WAIT_LOW: begin
        if (!data_ready_in) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Pointer, occupancy and output register next-state; a dequeue on a pre-edge empty queue is dropped
  always_comb begin
    rd_en    = dequeue_in && !empty_q;
    wr_ptr_d = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
    data_d  = rd_en ? mem[rd_ptr_q] : data_q;
    valid_d = rd_en;
  end

  // Control and output registers; reset abandons any in-flight handshake
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      data_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
    end
  end

  // Storage array; contents are don't-care after reset so it carries no reset
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= data_in;
    end
  end

  assign ack_out   = (state_q == ST_ACK);
  assign data_out  = data_q;
  assign out_valid = valid_q;
  assign len_out   = count_q;
  assign full      = full_q;
  assign empty     = empty_q;

endmodule

// File: tb/tb_byte_queue.sv
// tb/tb_byte_queue.sv - directed vector bench for byte_queue
module tb_byte_queue;

  logic       clock;
  logic       reset;
  logic [7:0] data_in;
  logic       data_ready_in;
  logic       ack_out;
  logic       dequeue_in;
  logic [7:0] data_out;
  logic       out_valid;
  logic [3:0] len_out;
  logic       full;
  logic       empty;

  int n_cmp;
  int n_fail;

  byte_queue #(.DEPTH(8), .WIDTH(8)) dut (
    .clock         (clock),
    .reset         (reset),
    .data_in       (data_in),
    .data_ready_in (data_ready_in),
    .ack_out       (ack_out),
    .dequeue_in    (dequeue_in),
    .data_out      (data_out),
    .out_valid     (out_valid),
    .len_out       (len_out),
    .full          (full),
    .empty         (empty)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       dr;
    logic [7:0] din;
    logic       deq;
    logic       ack;
    logic       vld;
    logic [7:0] dout;
    logic [3:0] len;
    logic       full;
    logic       empty;
  } vec_t;

  vec_t vt [27];
  logic [7:0] model [$];

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic enq(input logic [7:0] b);
    logic got;
    got           = 1'b0;
    data_in       = b;
    data_ready_in = 1'b1;
    for (int k = 0; k < 10 && !got; k++) begin
      step();
      if (ack_out) got = 1'b1;
    end
    chk($sformatf("enq_ack_%02h", b), 32'(got), 32'd1);
    data_ready_in = 1'b0;
    step();
    step();
  endtask

  task automatic deq(input logic [7:0] exp_b);
    dequeue_in = 1'b1;
    step();
    chk("deq_valid", 32'(out_valid), 32'd1);
    chk("deq_data", 32'(data_out), 32'(exp_b));
    dequeue_in = 1'b0;
  endtask

  initial begin
    n_cmp         = 0;
    n_fail        = 0;
    reset         = 1'b0;
    data_in       = 8'h00;
    data_ready_in = 1'b0;
    dequeue_in    = 1'b0;

    vt[0]  = '{1'b1, 8'hB6, 1'b0, 1'b1, 1'b0, 8'h00, 4'd1, 1'b0, 1'b0};
    vt[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 4'd1, 1'b0, 1'b0};
    vt[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 4'd1, 1'b0, 1'b0};
    vt[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hB6, 4'd0, 1'b0, 1'b1};
    vt[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hB6, 4'd0, 1'b0, 1'b1};
    vt[5]  = '{1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 8'hB6, 4'd1, 1'b0, 1'b0};
    for (int i = 6; i <= 11; i++)
      vt[i] = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 8'hB6, 4'd1, 1'b0, 1'b0};
    vt[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hB6, 4'd1, 1'b0, 1'b0};
    vt[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h55, 4'd0, 1'b0, 1'b1};
    vt[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h55, 4'd0, 1'b0, 1'b1};
    vt[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h55, 4'd0, 1'b0, 1'b1};
    vt[16] = '{1'b1, 8'h77, 1'b1, 1'b1, 1'b0, 8'h55, 4'd1, 1'b0, 1'b0};
    vt[17] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h77, 4'd0, 1'b0, 1'b1};
    vt[18] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h77, 4'd0, 1'b0, 1'b1};
    vt[19] = '{1'b1, 8'h81, 1'b0, 1'b1, 1'b0, 8'h77, 4'd1, 1'b0, 1'b0};
    vt[20] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h77, 4'd1, 1'b0, 1'b0};
    vt[21] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h77, 4'd1, 1'b0, 1'b0};
    vt[22] = '{1'b1, 8'h82, 1'b1, 1'b1, 1'b1, 8'h81, 4'd1, 1'b0, 1'b0};
    vt[23] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h81, 4'd1, 1'b0, 1'b0};
    vt[24] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h81, 4'd1, 1'b0, 1'b0};
    vt[25] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h82, 4'd0, 1'b0, 1'b1};
    vt[26] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h82, 4'd0, 1'b0, 1'b1};

    // reset then idle
    @(negedge clock);
    @(negedge clock);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_len", 32'(len_out), 32'd0);
    chk("rst_ack", 32'(ack_out), 32'd0);
    chk("rst_data", 32'(data_out), 32'h00);
    chk("rst_valid", 32'(out_valid), 32'd0);
    reset = 1'b1;
    step();
    chk("idle_len", 32'(len_out), 32'd0);

    // vector table: single byte, lingering data_ready, empty dequeue, simultaneous cases
    for (int i = 0; i < 27; i++) begin
      data_ready_in = vt[i].dr;
      data_in       = vt[i].din;
      dequeue_in    = vt[i].deq;
      step();
      chk($sformatf("vec%0d", i),
          32'({ack_out, out_valid, data_out, len_out, full, empty}),
          32'({vt[i].ack, vt[i].vld, vt[i].dout, vt[i].len, vt[i].full, vt[i].empty}));
    end
    data_ready_in = 1'b0;
    dequeue_in    = 1'b0;

    // fill, hold a ninth byte under back-pressure, release with one dequeue
    for (int b = 1; b <= 8; b++) enq(8'(b));
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_len", 32'(len_out), 32'd8);
    begin
      int acks;
      acks          = 0;
      data_in       = 8'h09;
      data_ready_in = 1'b1;
      for (int k = 0; k < 4; k++) begin
        step();
        if (ack_out) acks++;
      end
      chk("full_no_ack", 32'(acks), 32'd0);
      chk("full_hold_len", 32'(len_out), 32'd8);
      dequeue_in = 1'b1;
      step();
      dequeue_in = 1'b0;
      chk("full_deq_valid", 32'(out_valid), 32'd1);
      chk("full_deq_data", 32'(data_out), 32'h01);
      chk("full_deq_ack", 32'(ack_out), 32'd0);
      chk("full_deq_len", 32'(len_out), 32'd7);
      chk("full_deq_full", 32'(full), 32'd0);
      step();
      chk("held_ack", 32'(ack_out), 32'd1);
      chk("held_len", 32'(len_out), 32'd8);
      chk("held_full", 32'(full), 32'd1);
      data_ready_in = 1'b0;
      step();
      step();
    end
    for (int b = 2; b <= 9; b++) deq(8'(b));
    chk("drain_empty", 32'(empty), 32'd1);

    // wrap and ordering with occupancy cycling 1..4
    for (int i = 0; i < 20; i++) begin
      enq(8'(8'h10 + i));
      model.push_back(8'(8'h10 + i));
      chk("wrap_len_enq", 32'(len_out), 32'(model.size()));
      if (model.size() == 4) begin
        while (model.size() > 1) deq(model.pop_front());
        chk("wrap_len_deq", 32'(len_out), 32'(model.size()));
      end
    end
    while (model.size() > 0) deq(model.pop_front());
    chk("wrap_empty", 32'(empty), 32'd1);

    // reset while a fourth byte is in its ACK cycle
    enq(8'hA1);
    enq(8'hA2);
    enq(8'hA3);
    data_in       = 8'hA4;
    data_ready_in = 1'b1;
    step();
    chk("mid_ack", 32'(ack_out), 32'd1);
    chk("mid_len", 32'(len_out), 32'd4);
    reset = 1'b0;
    #1;
    chk("mid_rst_now",
        32'({ack_out, out_valid, data_out, len_out, full, empty}),
        32'({1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1}));
    data_ready_in = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    step();
    chk("post_rst_len", 32'(len_out), 32'd0);
    chk("post_rst_empty", 32'(empty), 32'd1);
    chk("post_rst_ack", 32'(ack_out), 32'd0);
    dequeue_in = 1'b1;
    step();
    dequeue_in = 1'b0;
    chk("post_rst_deq", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
